serial_operand_feeder: RTL and testbench

SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

---
 rtl/serial_operand_feeder.sv | 98 +++++++++
 tb/tb_serial_operand_feeder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder.sv
// Serialises two parallel operands LSB-first for a bit-serial adder.
// Provides first/last-bit markers for carry handling and a one-cycle done pulse.
module serial_operand_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             hold,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_shift;
    logic at_last;

    assign in_shift = (state_q == SHIFT);
    assign at_last  = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    a_sr_d = a_sr_q >> 1;
                    b_sr_d = b_sr_q >> 1;
                    if (at_last) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything except bit_valid is decoded from registered state only.
    assign a_bit     = in_shift & a_sr_q[0];
    assign b_bit     = in_shift & b_sr_q[0];
    assign bit_valid = in_shift & ~hold;
    assign first_bit = in_shift & (cnt_q == '0);
    assign last_bit  = in_shift & at_last;
    assign busy      = in_shift;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: transaction-level model checked every cycle
// plus directed transfers with hand-computed streams and cycle numbers.
module tb_serial_operand_feeder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             hold;
    logic             a_bit, b_bit, bit_valid, first_bit, last_bit, busy, done;

    serial_operand_feeder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .hold      (hold),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_valid (bit_valid),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: an in-flight transfer is the captured operand
    // pair plus the index of the bit being presented.
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    int               m_idx  = 0;
    logic [WIDTH-1:0] m_a    = '0;
    logic [WIDTH-1:0] m_b    = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_idx  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            if (!hold) begin
                if (m_idx == WIDTH - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_idx  = 0;
            m_a    = a_in;
            m_b    = b_in;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_bit",     a_bit,     m_busy ? m_a[m_idx] : 1'b0);
            chk("b_bit",     b_bit,     m_busy ? m_b[m_idx] : 1'b0);
            chk("bit_valid", bit_valid, m_busy && !hold);
            chk("first_bit", first_bit, m_busy && (m_idx == 0));
            chk("last_bit",  last_bit,  m_busy && (m_idx == WIDTH - 1));
            chk("busy",      busy,      m_busy);
            chk("done",      done,      m_done);
        end
    end

    // Runs one transfer from IDLE; cycle 1 is the cycle after the accepting edge.
    task automatic run_xfer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input int hold_after, input int hold_len, input bit mid_start,
                            output logic [WIDTH-1:0] astr, output logic [WIDTH-1:0] bstr,
                            output int first_c, output int last_c, output int done_c,
                            output int nvalid, output int ndone, output logic hold_a_or);
        int nhold;
        astr = '0; bstr = '0; first_c = -1; last_c = -1; done_c = -1;
        nvalid = 0; ndone = 0; hold_a_or = 1'b0; nhold = 0;
        a_in = a; b_in = b; hold = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            if (mid_start) begin
                start = (c >= 2 && c <= 4);
                a_in  = 8'hFF;
                b_in  = 8'hFF;
            end
            hold = (hold_after >= 0 && nvalid == hold_after && nhold < hold_len);
            #1;
            if (hold) begin
                nhold++;
                hold_a_or |= a_bit;
            end
            if (bit_valid && nvalid < WIDTH) begin
                astr[nvalid] = a_bit;
                bstr[nvalid] = b_bit;
                nvalid++;
            end
            if (first_bit && first_c < 0) first_c = c;
            if (last_bit && last_c < 0) last_c = c;
            if (done) begin
                done_c = c;
                ndone++;
            end
            tick();
        end
        hold  = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (done) ndone++;
            tick();
        end
    endtask

    logic [WIDTH-1:0] astr, bstr;
    int               first_c, last_c, done_c, nvalid, ndone;
    logic             hold_a_or;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f_cyc[2];
        int d_cyc[2];
        int nf, nd;
        logic idle_gap;

        // Reset held two cycles while start and operands are asserted.
        rst = 1'b0; start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; hold = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_outputs", {a_bit, b_bit, bit_valid, first_bit, last_bit, done}, 6'b0);
        rst = 1'b1; start = 1'b0;
        tick();
        chk("no_capture_busy", busy, 1'b0);

        // A5 / 3C, no stall.
        run_xfer(8'hA5, 8'h3C, -1, 0, 1'b0, astr, bstr, first_c, last_c, done_c, nvalid, ndone, hold_a_or);
        chk("plain_a_stream", astr, 8'hA5);
        chk("plain_b_stream", bstr, 8'h3C);
        chk("plain_nvalid", nvalid, 8);
        chk("plain_first_cycle", first_c, 1);
        chk("plain_last_cycle", last_c, 8);
        chk("plain_done_cycle", done_c, 9);
        chk("plain_ndone", ndone, 1);

        // Three-cycle stall after the third bit.
        run_xfer(8'hA5, 8'h3C, 3, 3, 1'b0, astr, bstr, first_c, last_c, done_c, nvalid, ndone, hold_a_or);
        chk("hold_a_stream", astr, 8'hA5);
        chk("hold_b_stream", bstr, 8'h3C);
        chk("hold_a_bit_during_stall", hold_a_or, 1'b0);
        chk("hold_last_cycle", last_c, 11);
        chk("hold_done_cycle", done_c, 12);

        // Start with new operands while shifting is ignored.
        run_xfer(8'h01, 8'h80, -1, 0, 1'b1, astr, bstr, first_c, last_c, done_c, nvalid, ndone, hold_a_or);
        chk("midstart_a_stream", astr, 8'h01);
        chk("midstart_b_stream", bstr, 8'h80);
        chk("midstart_ndone", ndone, 1);
        chk("midstart_done_cycle", done_c, 9);

        // Reset while bit 4 is presented, then restart immediately.
        a_in = 8'h5A; b_in = 8'hC3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_bit4_a", a_bit, 1'b1);
        chk("abort_bit4_b", b_bit, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_outputs", {a_bit, b_bit, bit_valid, first_bit, last_bit, done}, 6'b0);
        run_xfer(8'hC3, 8'h5A, -1, 0, 1'b0, astr, bstr, first_c, last_c, done_c, nvalid, ndone, hold_a_or);
        chk("restart_a_stream", astr, 8'hC3);
        chk("restart_b_stream", bstr, 8'h5A);
        chk("restart_first_cycle", first_c, 1);
        chk("restart_done_cycle", done_c, 9);

        // Start held high: back-to-back transfers with one IDLE cycle between.
        a_in = 8'h81; b_in = 8'h00; start = 1'b1; hold = 1'b0;
        nf = 0; nd = 0; idle_gap = 1'b1;
        f_cyc[0] = -1; f_cyc[1] = -1; d_cyc[0] = -1; d_cyc[1] = -1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (first_bit && nf < 2) begin f_cyc[nf] = c; nf++; end
            if (done && nd < 2) begin d_cyc[nd] = c; nd++; end
            if (c == 10) idle_gap = busy | done;
        end
        chk("b2b_first0", f_cyc[0], 1);
        chk("b2b_done0", d_cyc[0], 9);
        chk("b2b_idle_gap", idle_gap, 1'b0);
        chk("b2b_first1", f_cyc[1], 11);
        chk("b2b_done1", d_cyc[1], 19);
        start = 1'b0;
        repeat (10) tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
